// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the L2-side physical-memory line responder.
// Line/word/address typedefs, beat counter type and the responder FSM encoding.
package pmem_line_responder_pkg;

    localparam int LINE_W     = 128;
    localparam int WORD_W     = 16;
    localparam int PMEM_BEATS = LINE_W / WORD_W;
    localparam int BEAT_W     = $clog2(PMEM_BEATS);

    typedef logic [LINE_W-1:0] lc3b_pmem_line;
    typedef logic [15:0]       lc3b_pmem_addr;
    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } pmem_resp_state_t;

endpackage

// File: rtl/pmem_line_responder_buffer.sv
// Line register with per-beat word insert/extract and the beat counter.
// load wins over insert; load or clear resets the beat to 0.
module pmem_line_buffer
    import pmem_line_responder_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              insert,
    input  logic [WORD_W-1:0] insert_word,
    input  logic              inc,
    input  logic              clear,
    output logic [LINE_W-1:0] line_ins,
    output logic [WORD_W-1:0] word,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);

    lc3b_pmem_line line_q;
    beat_t         beat_q;

    // Current line with the incoming word spliced in at the current beat.
    always_comb begin
        line_ins = line_q;
        line_ins[WORD_W*beat_q +: WORD_W] = insert_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= '0;
            beat_q <= '0;
        end else begin
            if (load) begin
                line_q <= load_line;
            end else if (insert) begin
                line_q <= line_ins;
            end
            if (load || clear) begin
                beat_q <= '0;
            end else if (inc) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign word = line_q[WORD_W*beat_q +: WORD_W];
    assign beat = beat_q;
    assign last = (beat_q == beat_t'(PMEM_BEATS - 1));

endmodule

// File: rtl/pmem_line_responder.sv
// Services one 128-bit pmem line request as eight 16-bit SRAM transfers, then pulses pmem_resp.
// Optional PMEM_PROTO_CHECK_EN adds a sticky requester protocol checker on proto_err.
//
// Handshakes: pmem_read/pmem_write are levels held by the requester until the one-cycle
// pmem_resp; sram_read/sram_write are held until sram_resp, which completes the word in
// the same cycle it is seen high (zero-wait SRAMs answer in the strobe's first cycle).
module pmem_line_responder
    import pmem_line_responder_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [15:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              sram_read,
    output logic              sram_write,
    output logic [15:0]       sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata,
    input  logic              sram_resp,
    output logic              proto_err,
    output pmem_resp_state_t  state_dbg
);

    pmem_resp_state_t state, state_next;
    logic             hold_off;
    logic [11:0]      line_addr;
    logic             accept, buf_insert, buf_inc, buf_clear;
    lc3b_pmem_line    line_ins;
    beat_t            beat;
    logic             last;
    logic             addr_unused;

    assign addr_unused = ^pmem_address[3:0];

    pmem_line_buffer u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (accept),
        .load_line   (pmem_wdata),
        .insert      (buf_insert),
        .insert_word (sram_rdata),
        .inc         (buf_inc),
        .clear       (buf_clear),
        .line_ins    (line_ins),
        .word        (sram_wdata),
        .beat        (beat),
        .last        (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // hold_off keeps IDLE from re-accepting a request still high just after its pmem_resp.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!hold_off) begin
                    if (pmem_write)     state_next = WR;
                    else if (pmem_read) state_next = RD;
                end
            end
            RD:      if (sram_resp && last) state_next = RESP;
            WR:      if (sram_resp && last) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sram_read  = 1'b0;
        sram_write = 1'b0;
        pmem_resp  = 1'b0;
        accept     = 1'b0;
        buf_insert = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            IDLE:    accept     = !hold_off && (pmem_read || pmem_write);
            RD: begin
                sram_read  = 1'b1;
                buf_insert = sram_resp;
            end
            WR:      sram_write = 1'b1;
            RESP: begin
                pmem_resp  = 1'b1;
                buf_clear  = 1'b1;
            end
            default: ;
        endcase
        buf_inc = (sram_read || sram_write) && sram_resp && !last;
    end

    // pmem_rdata is loaded with the completed line on the final read beat so it is
    // already valid during the pmem_resp cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_addr  <= '0;
            hold_off   <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            if (accept) line_addr <= pmem_address[15:4];
            hold_off <= (state == RESP);
            if ((state == RD) && sram_resp && last) pmem_rdata <= line_ins;
        end
    end

    assign sram_addr = {line_addr, beat, 1'b0};
    assign state_dbg = state;

`ifdef PMEM_PROTO_CHECK_EN
    logic proto_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_q <= 1'b0;
        end else if (((state == IDLE) && pmem_read && pmem_write) ||
                     ((state == RD) && !pmem_read) ||
                     ((state == WR) && !pmem_write)) begin
            proto_q <= 1'b1;
        end
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
